// File: rtl/banked_lane_rom_pkg.sv
// Shared constants and default contents for banked_lane_rom.
// rom_word(i) defines the fixed word store; LANES is the default lane count per word.
package banked_lane_rom_pkg;

  localparam int DEF_WORD_W = 64;
  localparam int DEF_LANE_W = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int LANES      = DEF_WORD_W / DEF_LANE_W;

  function automatic logic [63:0] rom_word(input int i);
    logic [63:0] w;
    w = '0;
    if (i >= 0 && i <= 5) begin
      w = 64'(i + 1);
    end else if (i == 6) begin
      w = 64'h12;
    end else if (i == 7) begin
      w = 64'h11301;
    end
    return w;
  endfunction

endpackage

// File: rtl/banked_lane_rom_port.sv
// One read pipeline of banked_lane_rom: S1 word fetch, S2 lane select; 2-cycle latency, 1 read/cycle.
// Backpressure on rsp_ready holds S2 then S1, and drops req_ready. ROM_PARITY_EN adds rsp_par.
module banked_lane_rom_port
  import banked_lane_rom_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LANE_W = DEF_LANE_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int NL = WORD_W / LANE_W,
  localparam int IW = $clog2(DEPTH),
  localparam int LW = $clog2(NL),
  localparam int AW = IW + LW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] rom [DEPTH],
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [LANE_W-1:0] rsp_data,
  output logic              rsp_oor
`ifdef ROM_PARITY_EN
  ,
  output logic              rsp_par
`endif
);

  logic              rdy_en;
  logic              advance;
  logic [IW-1:0]     word_idx;
  logic              fetch_oor;
  logic [WORD_W-1:0] fetch_word;
  logic              s1_vld;
  logic              s1_oor;
  logic [WORD_W-1:0] s1_word;
  logic [LW-1:0]     s1_lane;
  logic [LANE_W-1:0] lane_dat;

  assign word_idx  = req_addr[AW-1 -: IW];
  assign fetch_oor = int'(word_idx) >= DEPTH;
  assign advance   = !rsp_valid || rsp_ready;
  assign req_ready = rdy_en && (!s1_vld || advance);

  always_comb begin
    fetch_word = '0;
    if (!fetch_oor) begin
      fetch_word = rom[word_idx];
    end
  end

  // Keeps req_ready low for the first cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_oor  <= 1'b0;
      s1_word <= '0;
      s1_lane <= '0;
    end else if (req_ready) begin
      s1_vld <= req_valid;
      if (req_valid) begin
        s1_word <= fetch_word;
        s1_lane <= req_addr[LW-1:0];
        s1_oor  <= fetch_oor;
      end
    end
  end

  // Lane 0 is the most significant lane of the word.
  always_comb begin
    lane_dat = '0;
    for (int k = 0; k < NL; k++) begin
      if (s1_lane == LW'(k)) begin
        lane_dat = s1_word[WORD_W-1-k*LANE_W -: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_oor   <= 1'b0;
    end else if (advance) begin
      rsp_valid <= s1_vld;
      if (s1_vld) begin
        rsp_data <= s1_oor ? '0 : lane_dat;
        rsp_oor  <= s1_oor;
      end
    end
  end

`ifdef ROM_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_par <= 1'b0;
    end else if (advance && s1_vld) begin
      rsp_par <= !s1_oor && (^lane_dat);
    end
  end
`endif

endmodule

// File: rtl/banked_lane_rom.sv
// Dual-port lane-addressed constant store; each port is an independent 2-cycle valid/ready read pipeline.
// Backpressure per port stalls only that port. ROM_PARITY_EN adds a_rsp_par/b_rsp_par.
module banked_lane_rom
  import banked_lane_rom_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LANE_W = DEF_LANE_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH) + $clog2(WORD_W / LANE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [AW-1:0]     a_req_addr,
  output logic              a_rsp_valid,
  input  logic              a_rsp_ready,
  output logic [LANE_W-1:0] a_rsp_data,
  output logic              a_rsp_oor,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [AW-1:0]     b_req_addr,
  output logic              b_rsp_valid,
  input  logic              b_rsp_ready,
  output logic [LANE_W-1:0] b_rsp_data,
  output logic              b_rsp_oor
`ifdef ROM_PARITY_EN
  ,
  output logic              a_rsp_par,
  output logic              b_rsp_par
`endif
);

  logic [WORD_W-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = WORD_W'(rom_word(i));
  end

  banked_lane_rom_port #(
    .WORD_W (WORD_W),
    .LANE_W (LANE_W),
    .DEPTH  (DEPTH)
  ) u_port_a (
`ifdef ROM_PARITY_EN
    .rsp_par   (a_rsp_par),
`endif
    .clk       (clk),
    .rst       (rst),
    .rom       (rom),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_addr  (a_req_addr),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (a_rsp_ready),
    .rsp_data  (a_rsp_data),
    .rsp_oor   (a_rsp_oor)
  );

  banked_lane_rom_port #(
    .WORD_W (WORD_W),
    .LANE_W (LANE_W),
    .DEPTH  (DEPTH)
  ) u_port_b (
`ifdef ROM_PARITY_EN
    .rsp_par   (b_rsp_par),
`endif
    .clk       (clk),
    .rst       (rst),
    .rom       (rom),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_addr  (b_req_addr),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_data  (b_rsp_data),
    .rsp_oor   (b_rsp_oor)
  );

endmodule
